// File: rtl/alu_seq_datapath.sv
// Multi-cycle ALU datapath: strobed operands, FSM execution with programmable latency, result FIFO.
// Optional feature: define ALU_SAT_EN to saturate ADD/SUB results instead of wrapping.
module alu_seq_datapath #(
    parameter int DATA_WIDTH  = 8,
    parameter int EXEC_CYCLES = 2,
    parameter int RES_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         store_a,
    input  logic                         store_b,
    input  logic [1:0]                   opcode_value,
    input  logic                         start,
    output logic                         start_ready,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         overflow_def,
    output logic                         alu_done,
    input  logic                         result_ready,
    output logic [$clog2(RES_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EC_W  = $clog2(EXEC_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PAR  = 2'b10;
    localparam logic [1:0] OP_COMP = 2'b11;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [DATA_WIDTH-1:0] op_a_r, op_b_r;
    logic [DATA_WIDTH-1:0] work_a_r, work_b_r;
    logic [1:0]            work_op_r;
    logic [1:0]            state_r;
    logic [EC_W-1:0]       exec_cnt_r;
    logic [DATA_WIDTH:0]   mem_r [RES_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  full_s, empty_s, launch_s, push_s, pop_s;
    logic [DATA_WIDTH:0]   sum_s;
    logic [DATA_WIDTH-1:0] alu_res_s;
    logic                  alu_flag_s;
    logic [DATA_WIDTH:0]   head_s;

    assign full_s      = (count_r == CNT_W'(RES_DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign start_ready = (state_r == ST_IDLE) && !full_s;
    assign launch_s    = start && start_ready;
    assign push_s      = (state_r == ST_WRITE);
    assign pop_s       = !empty_s && result_ready;
    assign busy        = (state_r == ST_EXEC) || (state_r == ST_WRITE);
    assign alu_done    = !empty_s;
    assign fifo_count  = count_r;
    assign head_s      = mem_r[rd_ptr_r];
    assign result      = empty_s ? {DATA_WIDTH{1'b0}} : head_s[DATA_WIDTH-1:0];
    assign overflow_def = empty_s ? 1'b0 : head_s[DATA_WIDTH];
    assign sum_s       = {1'b0, work_a_r} + {1'b0, work_b_r};

    // Result and flag for the snapshotted operation; only consumed in WRITE.
    always_comb begin
        alu_res_s  = {DATA_WIDTH{1'b0}};
        alu_flag_s = 1'b0;
        case (work_op_r)
            OP_ADD: begin
                alu_flag_s = sum_s[DATA_WIDTH];
`ifdef ALU_SAT_EN
                alu_res_s  = alu_flag_s ? {DATA_WIDTH{1'b1}} : sum_s[DATA_WIDTH-1:0];
`else
                alu_res_s  = sum_s[DATA_WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                alu_flag_s = (work_a_r < work_b_r);
`ifdef ALU_SAT_EN
                alu_res_s  = alu_flag_s ? {DATA_WIDTH{1'b0}} : (work_a_r - work_b_r);
`else
                alu_res_s  = work_a_r - work_b_r;
`endif
            end
            OP_PAR: begin
                alu_res_s  = {{(DATA_WIDTH-1){1'b0}}, parity_of(work_a_r ^ work_b_r)};
                alu_flag_s = 1'b0;
            end
            OP_COMP: begin
                alu_res_s  = work_a_r ~^ work_b_r;
                alu_flag_s = 1'b0;
            end
            default: begin
                alu_res_s  = {DATA_WIDTH{1'b0}};
                alu_flag_s = 1'b0;
            end
        endcase
    end

    // Operand registers, writable in any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_r <= {DATA_WIDTH{1'b0}};
            op_b_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (store_a) op_a_r <= alu_data;
            if (store_b) op_b_r <= alu_data;
        end
    end

    // Control FSM; a launch snapshots pre-edge operands so later stores cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            exec_cnt_r <= {EC_W{1'b0}};
            work_a_r   <= {DATA_WIDTH{1'b0}};
            work_b_r   <= {DATA_WIDTH{1'b0}};
            work_op_r  <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r    <= ST_EXEC;
                        exec_cnt_r <= {EC_W{1'b0}};
                        work_a_r   <= op_a_r;
                        work_b_r   <= op_b_r;
                        work_op_r  <= opcode_value;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt_r == EC_W'(EXEC_CYCLES - 1)) begin
                        state_r    <= ST_WRITE;
                        exec_cnt_r <= {EC_W{1'b0}};
                    end else begin
                        exec_cnt_r <= exec_cnt_r + EC_W'(1);
                    end
                end
                ST_WRITE: state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Result FIFO; a push never meets a full FIFO because launches are gated on !full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RES_DEPTH; i++) mem_r[i] <= {(DATA_WIDTH+1){1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {alu_flag_s, alu_res_s};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_datapath.sv
// Directed bench for alu_seq_datapath (DATA_WIDTH=8, EXEC_CYCLES=2, RES_DEPTH=4).
module tb_alu_seq_datapath;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       flag;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] alu_data;
    logic       store_a, store_b, start, result_ready;
    logic [1:0] opcode_value;
    logic       start_ready, busy, overflow_def, alu_done;
    logic [7:0] result;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;
    vec_t vecs[10];

    alu_seq_datapath #(.DATA_WIDTH(8), .EXEC_CYCLES(2), .RES_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .alu_data(alu_data), .store_a(store_a),
        .store_b(store_b), .opcode_value(opcode_value), .start(start),
        .start_ready(start_ready), .busy(busy), .result(result),
        .overflow_def(overflow_def), .alu_done(alu_done),
        .result_ready(result_ready), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        alu_data = a; store_a = 1'b1; step(); store_a = 1'b0;
        alu_data = b; store_b = 1'b1; step(); store_b = 1'b0;
    endtask

    task automatic launch(input logic [1:0] op);
        opcode_value = op; start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pop_one();
        result_ready = 1'b1; step(); result_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hF0, 8'h20, 2'b00, 8'h10, 1'b1};
        vecs[1] = '{8'h05, 8'h09, 2'b01, 8'hFC, 1'b1};
        vecs[2] = '{8'h03, 8'h01, 2'b10, 8'h01, 1'b0};
        vecs[3] = '{8'hAA, 8'h0F, 2'b11, 8'h5A, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 2'b00, 8'h46, 1'b0};
        vecs[5] = '{8'h09, 8'h05, 2'b01, 8'h04, 1'b0};
        vecs[6] = '{8'h05, 8'h05, 2'b01, 8'h00, 1'b0};
        vecs[7] = '{8'hFF, 8'h00, 2'b10, 8'h00, 1'b0};
        vecs[8] = '{8'hFF, 8'h01, 2'b00, 8'h00, 1'b1};
        vecs[9] = '{8'h3C, 8'h3C, 2'b11, 8'hFF, 1'b0};
`ifdef ALU_SAT_EN
        vecs[0].res = 8'hFF;
        vecs[1].res = 8'h00;
        vecs[8].res = 8'hFF;
`endif

        reset_n = 1'b0; alu_data = 8'h00; store_a = 1'b0; store_b = 1'b0;
        start = 1'b0; opcode_value = 2'b00; result_ready = 1'b0;
        step(); step();
        check("reset_alu_done", alu_done, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_start_ready", start_ready, 1'b1);
        check("reset_count", fifo_count, 3'd0);
        check("reset_result", result, 8'h00);
        reset_n = 1'b1;
        step();

        // Table: exact latency of EXEC_CYCLES+1 edges, then result/flag, then pop.
        for (int i = 0; i < 10; i++) begin
            load(vecs[i].a, vecs[i].b);
            launch(vecs[i].op);
            check($sformatf("v%0d_busy", i), busy, 1'b1);
            step();
            check($sformatf("v%0d_notdone1", i), alu_done, 1'b0);
            step();
            check($sformatf("v%0d_notdone2", i), alu_done, 1'b0);
            step();
            check($sformatf("v%0d_done", i), alu_done, 1'b1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flag", i), overflow_def, vecs[i].flag);
            check($sformatf("v%0d_count", i), fifo_count, 3'd1);
            pop_one();
            check($sformatf("v%0d_popped", i), alu_done, 1'b0);
        end

        // Store and start on the same edge: start sees pre-edge A.
        load(8'h01, 8'h01);
        alu_data = 8'h07; store_a = 1'b1; opcode_value = 2'b00; start = 1'b1;
        step();
        store_a = 1'b0; start = 1'b0;
        step(); step(); step();
        check("same_edge_result", result, 8'h02);
        pop_one();

        // Store during EXEC does not touch the in-flight op; next op sees it.
        load(8'h10, 8'h01);
        launch(2'b00);
        alu_data = 8'h20; store_a = 1'b1; step(); store_a = 1'b0;
        step(); step();
        check("inflight_old_a", result, 8'h11);
        pop_one();
        launch(2'b00);
        step(); step(); step();
        check("next_new_a", result, 8'h21);
        pop_one();

        // Fill FIFO with COMPs while blocked; fifth start is dropped.
        load(8'hAA, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            launch(2'b11);
            step(); step(); step();
        end
        check("full_count", fifo_count, 3'd4);
        check("full_start_ready", start_ready, 1'b0);
        launch(2'b11);
        check("drop_busy", busy, 1'b0);
        step(); step(); step(); step();
        check("drop_count", fifo_count, 3'd4);
        check("full_head", result, 8'h5A);
        pop_one();
        check("after_pop_ready", start_ready, 1'b1);
        check("after_pop_count", fifo_count, 3'd3);
        result_ready = 1'b1;
        step(); step(); step(); step();
        result_ready = 1'b0;
        check("drain_count", fifo_count, 3'd0);
        check("empty_result", result, 8'h00);
        check("empty_done", alu_done, 1'b0);

        // Fill with 1..4, drain one, then push and pop on the same edge.
        for (int k = 1; k <= 4; k++) begin
            load(8'(k), 8'h00);
            launch(2'b00);
            step(); step(); step();
        end
        check("fill2_count", fifo_count, 3'd4);
        check("fill2_head", result, 8'h01);
        pop_one();
        load(8'h05, 8'h00);
        launch(2'b00);
        step(); step();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("push_pop_count", fifo_count, 3'd3);
        for (int v = 3; v <= 5; v++) begin
            check($sformatf("order_%0d", v), result, 8'(v));
            pop_one();
        end
        check("order_empty", fifo_count, 3'd0);

        // Reset mid-EXEC flushes FIFO and operands.
        load(8'h01, 8'h02);
        launch(2'b00);
        step(); step(); step();
        check("pre_reset_count", fifo_count, 3'd1);
        launch(2'b00);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", alu_done, 1'b0);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_start_ready", start_ready, 1'b1);
        check("midrst_result", result, 8'h00);
        check("midrst_flag", overflow_def, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        launch(2'b01);
        step(); step(); step();
        check("post_rst_done", alu_done, 1'b1);
        check("post_rst_result", result, 8'h00);
        check("post_rst_flag", overflow_def, 1'b0);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
